// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory write port and one read port
// among NUM_REQ requesters, with a single-entry read-response stage.
//
// Ports:
//   clock, reset         rising-edge clock, async active-low reset
//   req_valid/we/addr/wdata  per-requester request (addr/wdata flattened,
//                            requester i at [i*AW +: AW] / [i*WIDTH +: WIDTH])
//   req_ready            one-hot grant, combinational
//   rsp_valid/ready      one-hot read response handshake
//   rsp_data             captured read data, shared by all requesters
//   mem_re/raddr/rdata   memory read port (rdata combinational)
//   mem_we/waddr/wdata   memory write port
module mem_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 32,
    parameter int AW      = $clog2(DEPTH)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    input  logic [NUM_REQ-1:0]       req_we,
    input  logic [NUM_REQ*AW-1:0]    req_addr,
    input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]       req_ready,
    output logic [NUM_REQ-1:0]       rsp_valid,
    input  logic [NUM_REQ-1:0]       rsp_ready,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     mem_re,
    output logic [AW-1:0]            mem_raddr,
    input  logic [WIDTH-1:0]         mem_rdata,
    output logic                     mem_we,
    output logic [AW-1:0]            mem_waddr,
    output logic [WIDTH-1:0]         mem_wdata
);

    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   owner;
    logic [WIDTH-1:0] rsp_data_q;

    logic               read_ok;
    logic [NUM_REQ-1:0] elig;
    logic               gnt_found;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_vld;
    logic               gnt_we;
    logic               rd_gnt;
    logic [AW-1:0]      gnt_addr;
    logic [WIDTH-1:0]   gnt_wdata;
    logic [IW-1:0]      rr_next;

    // A new read may only be granted if the response slot is free or is
    // being drained this very cycle. Stalled reads drop out of the search
    // so that writes behind them keep flowing.
    assign read_ok = (state == IDLE) || rsp_ready[owner];
    assign elig    = req_valid & (req_we | {NUM_REQ{read_ok}});

    always_comb begin
        logic [IW:0] idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = {1'b0, rr_ptr} + (IW+1)'(k);
            if (idx >= (IW+1)'(NUM_REQ)) begin
                idx = idx - (IW+1)'(NUM_REQ);
            end
            if (!gnt_found && elig[idx[IW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = idx[IW-1:0];
            end
        end
    end

    // Grants are suppressed combinationally while reset is held.
    assign gnt_vld   = gnt_found && reset;
    assign gnt_we    = req_we[gnt_idx];
    assign rd_gnt    = gnt_vld && !gnt_we;
    assign gnt_addr  = req_addr[int'(gnt_idx)*AW +: AW];
    assign gnt_wdata = req_wdata[int'(gnt_idx)*WIDTH +: WIDTH];

    assign rr_next = (gnt_idx == IW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        req_ready = '0;
        if (gnt_vld) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    assign mem_we    = gnt_vld && gnt_we;
    assign mem_waddr = mem_we ? gnt_addr : '0;
    assign mem_wdata = mem_we ? gnt_wdata : '0;

    assign mem_re    = rd_gnt;
    assign mem_raddr = mem_re ? gnt_addr : '0;

    // rsp_valid derives from the state register only, so an async reset
    // clears it at once without waiting for an edge.
    always_comb begin
        rsp_valid = '0;
        if (state == RESP) begin
            rsp_valid[owner] = 1'b1;
        end
    end

    assign rsp_data = rsp_data_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            owner      <= '0;
            rsp_data_q <= '0;
        end else begin
            if (gnt_vld) begin
                rr_ptr <= rr_next;
            end
            case (state)
                IDLE: begin
                    if (rd_gnt) begin
                        state      <= RESP;
                        owner      <= gnt_idx;
                        rsp_data_q <= mem_rdata;
                    end
                end
                RESP: begin
                    if (rsp_ready[owner]) begin
                        if (rd_gnt) begin
                            owner      <= gnt_idx;
                            rsp_data_q <= mem_rdata;
                        end else begin
                            state      <= IDLE;
                            owner      <= '0;
                            rsp_data_q <= '0;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    owner      <= '0;
                    rsp_data_q <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a
// behavioural 32-entry memory on the memory ports.
module tb_mem_port_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int AW = 5;

    logic           clock;
    logic           reset;
    logic [N-1:0]   req_valid;
    logic [N-1:0]   req_we;
    logic [N*AW-1:0] req_addr;
    logic [N*W-1:0] req_wdata;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   rsp_valid;
    logic [N-1:0]   rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           mem_re;
    logic [AW-1:0]  mem_raddr;
    logic [W-1:0]   mem_rdata;
    logic           mem_we;
    logic [AW-1:0]  mem_waddr;
    logic [W-1:0]   mem_wdata;

    logic [W-1:0] mem [32];

    int checks;
    int failures;

    mem_port_arbiter #(
        .NUM_REQ(N), .WIDTH(W), .DEPTH(32), .AW(AW)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .mem_re(mem_re), .mem_raddr(mem_raddr),
        .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr),
        .mem_wdata(mem_wdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    assign mem_rdata = mem[mem_raddr];
    always @(posedge clock) begin
        if (mem_we) mem[mem_waddr] <= mem_wdata;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_req(input int i, input logic we,
                           input logic [AW-1:0] a, input logic [W-1:0] d);
        req_we[i] = we;
        req_addr[i*AW +: AW] = a;
        req_wdata[i*W +: W] = d;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        req_valid = 4'hF;
        rsp_ready = 4'hF;
        for (int i = 0; i < N; i++) set_req(i, 1'b1, AW'(i + 1), 32'h1000_0000 + i);
        #3;
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL rst_ready got=%b exp=0000", req_ready);
        end
        checks++;
        if (mem_we !== 1'b0 || mem_waddr !== 5'd0 || mem_wdata !== 32'd0) begin
            failures++;
            $display("FAIL rst_mem got we=%b a=%h d=%h exp 0", mem_we, mem_waddr, mem_wdata);
        end
        checks++;
        if (rsp_valid !== 4'b0000 || rsp_data !== 32'd0 || mem_re !== 1'b0) begin
            failures++;
            $display("FAIL rst_rsp got v=%b d=%h re=%b exp 0", rsp_valid, rsp_data, mem_re);
        end
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_rr_writes();
        logic [N-1:0] exp;
        for (int c = 0; c < 5; c++) begin
            #2;
            exp = 4'b0001 << (c % 4);
            checks++;
            if (req_ready !== exp || mem_we !== 1'b1) begin
                failures++;
                $display("FAIL rr_grant%0d got=%b we=%b exp=%b we=1", c, req_ready, mem_we, exp);
            end
            checks++;
            if (mem_waddr !== AW'(c % 4 + 1) || mem_wdata !== 32'h1000_0000 + (c % 4)) begin
                failures++;
                $display("FAIL rr_data%0d got a=%h d=%h", c, mem_waddr, mem_wdata);
            end
            tick();
        end
        req_valid = '0;
    endtask

    task automatic test_write_read();
        req_valid = 4'b0100;
        set_req(2, 1'b1, 5'd7, 32'hA5A5_A5A5);
        #2;
        checks++;
        if (req_ready !== 4'b0100 || mem_we !== 1'b1 || mem_waddr !== 5'd7) begin
            failures++;
            $display("FAIL wr7 got r=%b we=%b a=%h exp 0100 1 07", req_ready, mem_we, mem_waddr);
        end
        tick();
        set_req(2, 1'b0, 5'd7, 32'h0);
        #2;
        checks++;
        if (req_ready !== 4'b0100 || mem_re !== 1'b1 || mem_raddr !== 5'd7
            || mem_we !== 1'b0 || mem_waddr !== 5'd0) begin
            failures++;
            $display("FAIL rd7 got r=%b re=%b ra=%h we=%b wa=%h", req_ready, mem_re, mem_raddr, mem_we, mem_waddr);
        end
        tick();
        req_valid = '0;
        #2;
        checks++;
        if (rsp_valid !== 4'b0100 || rsp_data !== 32'hA5A5_A5A5) begin
            failures++;
            $display("FAIL rsp7 got v=%b d=%h exp 0100 a5a5a5a5", rsp_valid, rsp_data);
        end
        tick();
        checks++;
        if (rsp_valid !== 4'b0000 || rsp_data !== 32'd0) begin
            failures++;
            $display("FAIL idle_clr got v=%b d=%h exp 0", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_stall();
        rsp_ready = 4'b0000;
        req_valid = 4'b0010;
        set_req(1, 1'b0, 5'd7, 32'h0);
        #2;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL st_rd1 got=%b exp=0010", req_ready);
        end
        tick();
        set_req(3, 1'b0, 5'd3, 32'h0);
        set_req(0, 1'b1, 5'd7, 32'h1234_5678);
        req_valid = 4'b1001;
        for (int c = 0; c < 3; c++) begin
            #2;
            checks++;
            if (req_ready !== (c == 0 ? 4'b0001 : 4'b0000)) begin
                failures++;
                $display("FAIL st_gnt%0d got=%b", c, req_ready);
            end
            checks++;
            if (rsp_valid !== 4'b0010 || rsp_data !== 32'hA5A5_A5A5) begin
                failures++;
                $display("FAIL st_hold%0d got v=%b d=%h exp 0010 a5a5a5a5", c, rsp_valid, rsp_data);
            end
            tick();
            if (c == 0) req_valid = 4'b1000;
        end
        rsp_ready = 4'b0010;
        #2;
        checks++;
        if (req_ready !== 4'b1000 || mem_raddr !== 5'd3) begin
            failures++;
            $display("FAIL st_rel got r=%b ra=%h exp 1000 03", req_ready, mem_raddr);
        end
        tick();
        req_valid = '0;
        rsp_ready = 4'hF;
        #2;
        checks++;
        if (rsp_valid !== 4'b1000 || rsp_data !== 32'h1000_0002) begin
            failures++;
            $display("FAIL st_rsp3 got v=%b d=%h exp 1000 10000002", rsp_valid, rsp_data);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        rsp_ready = 4'hF;
        req_valid = 4'b0001;
        set_req(0, 1'b0, 5'd1, 32'h0);
        set_req(1, 1'b0, 5'd2, 32'h0);
        #2;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL b2b_g0 got=%b exp=0001", req_ready);
        end
        tick();
        req_valid = 4'b0010;
        #2;
        checks++;
        if (req_ready !== 4'b0010 || rsp_valid !== 4'b0001 || rsp_data !== 32'h1000_0000) begin
            failures++;
            $display("FAIL b2b_r0 got r=%b v=%b d=%h", req_ready, rsp_valid, rsp_data);
        end
        tick();
        req_valid = '0;
        #2;
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 32'h1000_0001) begin
            failures++;
            $display("FAIL b2b_r1 got v=%b d=%h exp 0010 10000001", rsp_valid, rsp_data);
        end
        tick();
        checks++;
        if (rsp_valid !== 4'b0000) begin
            failures++;
            $display("FAIL b2b_idle got=%b exp=0000", rsp_valid);
        end
    endtask

    task automatic test_reset_in_resp();
        rsp_ready = 4'b0000;
        req_valid = 4'b0010;
        set_req(1, 1'b0, 5'd7, 32'h0);
        tick();
        req_valid = 4'b1000;
        set_req(3, 1'b1, 5'd9, 32'hCAFE_0003);
        #2;
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_data !== 32'h1234_5678) begin
            failures++;
            $display("FAIL rr_pre got v=%b d=%h exp 0010 12345678", rsp_valid, rsp_data);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 4'b0000 || rsp_data !== 32'd0 || req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL rr_async got v=%b d=%h r=%b exp 0", rsp_valid, rsp_data, req_ready);
        end
        tick();
        reset = 1'b1;
        rsp_ready = 4'hF;
        #2;
        checks++;
        if (req_ready !== 4'b1000 || mem_waddr !== 5'd9) begin
            failures++;
            $display("FAIL rr_first got r=%b a=%h exp 1000 09", req_ready, mem_waddr);
        end
        tick();
        req_valid = '0;
    endtask

    task automatic test_single();
        req_valid = 4'b0100;
        set_req(2, 1'b1, 5'd12, 32'h0BAD_F00D);
        for (int c = 0; c < 10; c++) begin
            #2;
            checks++;
            if (req_ready !== 4'b0100 || mem_we !== 1'b1) begin
                failures++;
                $display("FAIL single%0d got r=%b we=%b exp 0100 1", c, req_ready, mem_we);
            end
            tick();
            checks++;
            if (dut.rr_ptr !== 2'd3) begin
                failures++;
                $display("FAIL single_ptr%0d got=%0d exp=3", c, dut.rr_ptr);
            end
        end
        req_valid = '0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 32; i++) mem[i] = '0;
        req_valid = '0;
        req_we = '0;
        req_addr = '0;
        req_wdata = '0;
        rsp_ready = '0;
        reset = 1'b0;
        #1;
        test_reset();
        test_rr_writes();
        test_write_read();
        test_stall();
        test_back_to_back();
        test_reset_in_resp();
        test_single();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
